// File: rtl/pipeline_step_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_step_ctrl
//
// Central sequencer for the five-stage pipeline's inter-stage registers.
// Produces the global step enable, the IF/ID stall/flush, the PC write enable
// and the ID/EX bubble. Supports continuous and single-step (debug) execution,
// drains the pipeline once a HALT has been decoded, and counts executed cycles.
// State changes on the rising edge of i_clk; every output is either a register
// or a short combinational function of registers and hazard inputs, so it is
// settled well before the pipeline registers capture on the falling edge.
//
// Ports
//   i_clk           clock
//   i_reset_n       asynchronous active-low reset
//   i_mode_cont     1 = continuous, 0 = single-step (sampled only in IDLE)
//   i_start         run request (rising-edge detected)
//   i_step_req      single-step request (rising-edge detected)
//   i_load_use      load-use hazard detected in ID
//   i_branch_taken  control redirect resolved in EX
//   i_halt_dec      HALT instruction present in ID
//   i_wb_halt       HALT has reached WB
//   o_step          global pipeline register enable
//   o_pc_write      PC update enable
//   o_if_id_stall   hold IF/ID
//   o_if_id_flush   zero the IF/ID instruction, keep PC+4
//   o_id_ex_flush   insert a bubble into ID/EX
//   o_running       RUN, STEP_WAIT, STEP_PULSE or DRAIN
//   o_halted        HALTED
//   o_cycle_count   number of cycles with o_step=1, saturating at all-ones
// -----------------------------------------------------------------------------
module pipeline_step_ctrl #(
  parameter int NB_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_mode_cont,
  input  logic              i_start,
  input  logic              i_step_req,
  input  logic              i_load_use,
  input  logic              i_branch_taken,
  input  logic              i_halt_dec,
  input  logic              i_wb_halt,
  output logic              o_step,
  output logic              o_pc_write,
  output logic              o_if_id_stall,
  output logic              o_if_id_flush,
  output logic              o_id_ex_flush,
  output logic              o_running,
  output logic              o_halted,
  output logic [NB_CNT-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RUN        = 3'd1,
    ST_STEP_WAIT  = 3'd2,
    ST_STEP_PULSE = 3'd3,
    ST_DRAIN      = 3'd4,
    ST_HALTED     = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic              r_start_q;
  logic              r_step_q;
  logic              r_halt_seen;
  logic [NB_CNT-1:0] r_cycle_count;

  logic              w_start_evt;
  logic              w_step_evt;
  logic              w_step;
  logic              w_halt_acc;
  logic              w_drain_mode;
  logic              w_cnt_full;

  // A request held high produces one event: compare against last cycle's level.
  assign w_start_evt = i_start    & ~r_start_q;
  assign w_step_evt  = i_step_req & ~r_step_q;

  // A HALT only counts when the pipeline actually advances and ID is neither
  // squashed by a redirect nor held by a load-use stall; a stalled HALT stays
  // in ID and is simply accepted on a later cycle.
  assign w_halt_acc = i_halt_dec & w_step & ~i_branch_taken & ~i_load_use;

  // Once a HALT is in flight, no new instructions may enter IF/ID.
  assign w_drain_mode = (r_state == ST_DRAIN) |
                        ((r_state == ST_STEP_PULSE) & r_halt_seen);

  assign w_cnt_full = &r_cycle_count;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_evt) begin
          w_next_state = i_mode_cont ? ST_RUN : ST_STEP_WAIT;
        end
      end
      ST_RUN: begin
        if (w_halt_acc) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_STEP_WAIT: begin
        // The drained HALT reaching WB ends the session even if a new
        // step request arrives in the same cycle.
        if (i_wb_halt && r_halt_seen) begin
          w_next_state = ST_HALTED;
        end else if (w_step_evt) begin
          w_next_state = ST_STEP_PULSE;
        end
      end
      ST_STEP_PULSE: begin
        w_next_state = ST_STEP_WAIT;
      end
      ST_DRAIN: begin
        if (i_wb_halt) begin
          w_next_state = ST_HALTED;
        end
      end
      ST_HALTED: begin
        w_next_state = ST_HALTED;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_step        = 1'b0;
    o_pc_write    = 1'b0;
    o_if_id_stall = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_running     = 1'b0;
    o_halted      = 1'b0;

    case (r_state)
      ST_RUN: begin
        w_step    = 1'b1;
        o_running = 1'b1;
      end
      ST_STEP_WAIT: begin
        o_running = 1'b1;
      end
      ST_STEP_PULSE: begin
        w_step    = 1'b1;
        o_running = 1'b1;
      end
      ST_DRAIN: begin
        w_step    = 1'b1;
        o_running = 1'b1;
      end
      ST_HALTED: begin
        o_halted = 1'b1;
      end
      default: begin
      end
    endcase

    // Hazard handling only matters when the pipeline registers move.
    // A taken branch outranks load-use: the stalled instruction is on the
    // wrong path anyway and gets squashed.
    if (w_step) begin
      if (i_branch_taken) begin
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
        o_pc_write    = 1'b1;
      end else if (i_load_use) begin
        o_if_id_stall = 1'b1;
        o_id_ex_flush = 1'b1;
      end else if (w_drain_mode) begin
        o_if_id_flush = 1'b1;
      end else begin
        o_pc_write = 1'b1;
      end
    end
  end

  assign o_step        = w_step;
  assign o_cycle_count = r_cycle_count;

  // ---------------------------------------------------------------------------
  // Request edge detectors
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_start_q <= 1'b0;
      r_step_q  <= 1'b0;
    end else begin
      r_start_q <= i_start;
      r_step_q  <= i_step_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Single-step halt tracking: a HALT accepted during a step pulse turns every
  // later step into a drain step until the HALT shows up in WB.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_halt_seen <= 1'b0;
    end else if ((r_state == ST_STEP_PULSE) && w_halt_acc) begin
      r_halt_seen <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Executed-cycle counter, saturating
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cycle_count <= '0;
    end else if (w_step && !w_cnt_full) begin
      r_cycle_count <= r_cycle_count + NB_CNT'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
module tb_pipeline_step_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mode, start, step_req, load_use, branch, halt_dec, wb_halt;

  logic        o_step, o_pc_write, o_stall, o_flush, o_idex, o_running, o_halted;
  logic [31:0] o_cnt;

  logic        s_step, s_pc_write, s_stall, s_flush, s_idex, s_running, s_halted;
  logic [2:0]  s_cnt;

  int n_checks;
  int n_fail;

  pipeline_step_ctrl #(.NB_CNT(32)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_mode_cont(mode), .i_start(start),
    .i_step_req(step_req), .i_load_use(load_use), .i_branch_taken(branch),
    .i_halt_dec(halt_dec), .i_wb_halt(wb_halt),
    .o_step(o_step), .o_pc_write(o_pc_write), .o_if_id_stall(o_stall),
    .o_if_id_flush(o_flush), .o_id_ex_flush(o_idex), .o_running(o_running),
    .o_halted(o_halted), .o_cycle_count(o_cnt)
  );

  // Narrow counter copy, used to observe saturation in a few cycles.
  pipeline_step_ctrl #(.NB_CNT(3)) dut_sat (
    .i_clk(clk), .i_reset_n(rst_n), .i_mode_cont(mode), .i_start(start),
    .i_step_req(step_req), .i_load_use(load_use), .i_branch_taken(branch),
    .i_halt_dec(halt_dec), .i_wb_halt(wb_halt),
    .o_step(s_step), .o_pc_write(s_pc_write), .o_if_id_stall(s_stall),
    .o_if_id_flush(s_flush), .o_id_ex_flush(s_idex), .o_running(s_running),
    .o_halted(s_halted), .o_cycle_count(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mode = 1'b0; start = 1'b0; step_req = 1'b0; load_use = 1'b0;
    branch = 1'b0; halt_dec = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start_session(input logic cont);
    mode  = cont;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #3;
    n_checks++;
    if ({o_step, o_pc_write, o_stall, o_flush, o_idex, o_running, o_halted} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {o_step, o_pc_write, o_stall, o_flush, o_idex, o_running, o_halted});
    end
    n_checks++;
    if (o_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d want 0", o_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({o_step, o_running, o_halted, o_cnt} !== 35'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: step=%b run=%b halt=%b cnt=%0d want all 0",
               o_step, o_running, o_halted, o_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_continuous();
    for (int r = 0; r < 2; r++) begin
      int n;
      logic [31:0] exp_cnt;
      logic [2:0]  exp_sat;
      n = (r == 0) ? 10 : int'($urandom_range(8, 30));
      apply_reset();
      start_session(1'b1);
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if ({o_step, o_pc_write, o_running, o_halted} !== 4'b1110) begin
          n_fail++;
          $display("FAIL cont_cycle%0d: step/pcw/run/halt=%b want 1110", i,
                   {o_step, o_pc_write, o_running, o_halted});
        end
        if (i == 3) start = 1'b1;  // a new start while running changes nothing
        tick();
      end
      start = 1'b0;
      exp_cnt = 32'(n);
      exp_sat = (n >= 7) ? 3'd7 : 3'(n);
      n_checks++;
      if (o_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL cont_count: got %0d want %0d", o_cnt, exp_cnt);
      end
      n_checks++;
      if (s_cnt !== exp_sat) begin
        n_fail++;
        $display("FAIL cont_count_saturate: got %0d want %0d", s_cnt, exp_sat);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_step();
    for (int r = 0; r < 2; r++) begin
      logic pat[$];
      logic prev;
      int   exp_pulses;
      int   pulses;
      logic last_step;
      logic [31:0] exp_cnt;
      apply_reset();
      start_session(1'b0);
      n_checks++;
      if ({o_step, o_running} !== 2'b01) begin
        n_fail++;
        $display("FAIL step_wait_entry: step/run=%b want 01", {o_step, o_running});
      end
      // held high for 5 cycles, then 3 separate pulses
      pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      if (r == 1) begin
        for (int k = 0; k < 24; k++) pat.push_back(1'($urandom_range(0, 1)));
      end
      pat.push_back(1'b0);
      pat.push_back(1'b0);
      exp_pulses = 0;
      prev = 1'b0;
      foreach (pat[k]) begin
        if (pat[k] && !prev) exp_pulses++;
        prev = pat[k];
      end
      pulses = 0;
      last_step = 1'b0;
      foreach (pat[k]) begin
        step_req = pat[k];
        tick();
        if (o_step) pulses++;
        n_checks++;
        if (o_step && last_step) begin
          n_fail++;
          $display("FAIL step_pulse_width: o_step high two cycles in a row at %0d", k);
        end
        last_step = o_step;
      end
      n_checks++;
      if (pulses !== exp_pulses) begin
        n_fail++;
        $display("FAIL step_pulse_count: got %0d want %0d", pulses, exp_pulses);
      end
      exp_cnt = 32'(exp_pulses);
      n_checks++;
      if (o_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL step_count: got %0d want %0d", o_cnt, exp_cnt);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_hazard();
    logic [3:0] exp;
    apply_reset();
    start_session(1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i == 0)      begin load_use = 1'b1; branch = 1'b1; end
      else if (i == 1) begin load_use = 1'b1; branch = 1'b0; end
      else begin
        load_use = 1'($urandom_range(0, 1));
        branch   = 1'($urandom_range(0, 1));
      end
      #1;
      // {stall, if_id_flush, id_ex_flush, pc_write}
      if (branch)        exp = 4'b0111;
      else if (load_use) exp = 4'b1010;
      else               exp = 4'b0001;
      n_checks++;
      if ({o_stall, o_flush, o_idex, o_pc_write} !== exp) begin
        n_fail++;
        $display("FAIL hazard_%0d lu=%b br=%b: stall/flush/idex/pcw=%b want %b", i,
                 load_use, branch, {o_stall, o_flush, o_idex, o_pc_write}, exp);
      end
      tick();
    end
    // hazards are masked while the pipeline is not stepping
    apply_reset();
    start_session(1'b0);
    load_use = 1'b1;
    branch   = 1'b1;
    #1;
    n_checks++;
    if ({o_step, o_stall, o_flush, o_idex, o_pc_write} !== 5'b0) begin
      n_fail++;
      $display("FAIL hazard_gated: step/stall/flush/idex/pcw=%b want 00000",
               {o_step, o_stall, o_flush, o_idex, o_pc_write});
    end
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_halt_drain();
    for (int r = 0; r < 2; r++) begin
      int d;
      logic [31:0] cnt_before, exp_cnt;
      d = (r == 0) ? 2 : int'($urandom_range(1, 6));
      apply_reset();
      start_session(1'b1);
      repeat ($urandom_range(2, 6)) tick();
      cnt_before = o_cnt;
      halt_dec = 1'b1;
      tick();
      halt_dec = 1'b0;
      for (int i = 0; i <= d; i++) begin
        if (i == d) wb_halt = 1'b1;
        #1;
        n_checks++;
        if ({o_step, o_pc_write, o_flush, o_running} !== 4'b1011) begin
          n_fail++;
          $display("FAIL drain_cycle%0d: step/pcw/flush/run=%b want 1011", i,
                   {o_step, o_pc_write, o_flush, o_running});
        end
        tick();
      end
      wb_halt = 1'b0;
      exp_cnt = cnt_before + 32'(d) + 32'd2;
      n_checks++;
      if ({o_halted, o_running, o_step, o_pc_write, o_stall, o_flush, o_idex} !== 7'b1000000) begin
        n_fail++;
        $display("FAIL halted_outputs: halt/run/step/pcw/stall/flush/idex=%b want 1000000",
                 {o_halted, o_running, o_step, o_pc_write, o_stall, o_flush, o_idex});
      end
      n_checks++;
      if (o_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL halt_count: got %0d want %0d", o_cnt, exp_cnt);
      end
      // requests are ignored once halted; the counter stays frozen
      start = 1'b1; step_req = 1'b1; mode = 1'b1;
      repeat (4) tick();
      start = 1'b0; step_req = 1'b0;
      n_checks++;
      if ({o_halted, o_step} !== 2'b10 || o_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL halt_frozen: halt=%b step=%b cnt=%0d want 1 0 %0d",
                 o_halted, o_step, o_cnt, exp_cnt);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_squashed_halt();
    apply_reset();
    start_session(1'b1);
    halt_dec = 1'b1;
    branch   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({o_running, o_halted} !== 2'b10) begin
        n_fail++;
        $display("FAIL squash_%0d: run/halt=%b want 10", i, {o_running, o_halted});
      end
    end
    halt_dec = 1'b0;
    branch   = 1'b0;
    #1;
    n_checks++;
    if ({o_pc_write, o_flush} !== 2'b10) begin
      n_fail++;
      $display("FAIL squash_not_draining: pcw/flush=%b want 10", {o_pc_write, o_flush});
    end
    // a halt held behind a load-use stall is accepted once the stall clears
    halt_dec = 1'b1;
    load_use = 1'b1;
    tick();
    load_use = 1'b0;
    #1;
    n_checks++;
    if ({o_pc_write, o_flush} !== 2'b10) begin
      n_fail++;
      $display("FAIL stalled_halt_ignored: pcw/flush=%b want 10", {o_pc_write, o_flush});
    end
    tick();
    halt_dec = 1'b0;
    #1;
    n_checks++;
    if ({o_step, o_pc_write, o_flush} !== 3'b101) begin
      n_fail++;
      $display("FAIL stalled_halt_retry: step/pcw/flush=%b want 101",
               {o_step, o_pc_write, o_flush});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_step_halt();
    apply_reset();
    start_session(1'b0);
    step_req = 1'b1;
    halt_dec = 1'b1;
    tick();
    n_checks++;
    if ({o_step, o_pc_write} !== 2'b11) begin
      n_fail++;
      $display("FAIL step_halt_pulse: step/pcw=%b want 11", {o_step, o_pc_write});
    end
    tick();
    step_req = 1'b0;
    halt_dec = 1'b0;
    tick();
    step_req = 1'b1;
    tick();
    n_checks++;
    if ({o_step, o_pc_write, o_flush} !== 3'b101) begin
      n_fail++;
      $display("FAIL step_drain_pulse: step/pcw/flush=%b want 101",
               {o_step, o_pc_write, o_flush});
    end
    step_req = 1'b0;
    tick();
    wb_halt = 1'b1;
    tick();
    wb_halt = 1'b0;
    n_checks++;
    if ({o_halted, o_running, o_cnt} !== {2'b10, 32'd2}) begin
      n_fail++;
      $display("FAIL step_halted: halt=%b run=%b cnt=%0d want 1 0 2",
               o_halted, o_running, o_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    apply_reset();
    start_session(1'b1);
    repeat (3) tick();
    halt_dec = 1'b1;
    tick();
    halt_dec = 1'b0;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_step, o_pc_write, o_stall, o_flush, o_idex, o_running, o_halted} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b want 0000000",
               {o_step, o_pc_write, o_stall, o_flush, o_idex, o_running, o_halted});
    end
    n_checks++;
    if (o_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset_count: got %0d want 0", o_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_session(1'b1);
    repeat (3) tick();
    n_checks++;
    if ({o_step, o_pc_write, o_running} !== 3'b111 || o_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL resume_after_reset: step/pcw/run=%b cnt=%0d want 111 3",
               {o_step, o_pc_write, o_running}, o_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clear_inputs();
    test_reset();
    test_continuous();
    test_step();
    test_hazard();
    test_halt_drain();
    test_squashed_halt();
    test_step_halt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
